// File: rtl/rfid_pkg.sv
// Shared RFID air-interface definitions: PIE encoder states, symbol codes and
// the default link timing (in ticks) used by both link directions.
package rfid_pkg;

  localparam int PIE_TICK_N = 10;
  localparam int PIE_DELIM  = 20;
  localparam int PIE_TARI   = 16;
  localparam int PIE_DATA1  = 28;
  localparam int PIE_PW     = 8;
  localparam int PIE_RTCAL  = 44;
  localparam int PIE_TRCAL  = 88;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_DELIM,
    ST_DATA0,
    ST_RTCAL,
    ST_TRCAL,
    ST_DATA
  } pie_state_e;

  typedef enum logic [2:0] {
    SYM_DELIM,
    SYM_DATA0,
    SYM_DATA1,
    SYM_RTCAL,
    SYM_TRCAL
  } pie_sym_e;

  // Counter width able to hold 0..maxVal-1, never narrower than one bit.
  function automatic int ctrWidth(input int maxVal);
    return (maxVal > 1) ? $clog2(maxVal) : 1;
  endfunction

endpackage

// File: rtl/pie_sym_timer.sv
// Symbol timer: a TICK_N prescaler driving a per-symbol tick phase counter.
// 'level' is the line level for the cycle that follows the current clock edge.
module pie_sym_timer #(
  parameter int TICK_N = 10,
  parameter int PW     = 8,
  parameter int TICK_W = 4,
  parameter int PH_W   = 7
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            run,
  input  logic            load,
  input  logic            low_only,
  input  logic [PH_W-1:0] sym_len,
  output logic            level,
  output logic            sym_last
);

  localparam logic [TICK_W-1:0] TICK_MAX = TICK_W'(TICK_N - 1);
  localparam logic [TICK_W-1:0] ONE_T    = TICK_W'(1);
  localparam logic [PH_W-1:0]   ONE_P    = PH_W'(1);
  localparam logic [PH_W-1:0]   PW_L     = PH_W'(PW);

  logic [TICK_W-1:0] tick_q, tick_d;
  logic [PH_W-1:0]   phase_q, phase_d;
  logic [PH_W-1:0]   len_q, len_d;
  logic              low_q, low_d;

  assign sym_last = run && (tick_q == TICK_MAX) && (phase_q == len_q - ONE_P);

  always_comb begin
    tick_d  = tick_q;
    phase_d = phase_q;
    len_d   = len_q;
    low_d   = low_q;
    if (load) begin
      tick_d  = '0;
      phase_d = '0;
      len_d   = sym_len;
      low_d   = low_only;
    end else if (run) begin
      if (tick_q == TICK_MAX) begin
        tick_d  = '0;
        phase_d = (phase_q == len_q - ONE_P) ? '0 : phase_q + ONE_P;
      end else begin
        tick_d = tick_q + ONE_T;
      end
    end else begin
      tick_d  = '0;
      phase_d = '0;
    end
    // Every symbol ends with PW low ticks; a delimiter is low throughout.
    level = !low_d && (phase_d < (len_d - PW_L));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tick_q  <= '0;
      phase_q <= '0;
      len_q   <= '0;
      low_q   <= 1'b0;
    end else begin
      tick_q  <= tick_d;
      phase_q <= phase_d;
      len_q   <= len_d;
      low_q   <= low_d;
    end
  end

endmodule

// File: rtl/pie_encoder.sv
// Reader-to-tag PIE encoder: delimiter, data-0, RTcal, optional TRcal, then
// command bits pulled over a valid/ready stream until the bit flagged last.
module pie_encoder
  import rfid_pkg::*;
#(
  parameter int TICK_N = PIE_TICK_N,
  parameter int DELIM  = PIE_DELIM,
  parameter int TARI   = PIE_TARI,
  parameter int DATA1  = PIE_DATA1,
  parameter int PW     = PIE_PW,
  parameter int RTCAL  = PIE_RTCAL,
  parameter int TRCAL  = PIE_TRCAL
) (
  input  logic clk,
  input  logic rst_n,
  input  logic start,
  input  logic preamble_sel,
  input  logic in_dat,
  input  logic in_last,
  input  logic in_vld,
  output logic in_rdy,
  output logic tx_out,
  output logic busy,
  output logic done,
  output logic underrun
);

  localparam int TICK_W = ctrWidth(TICK_N);
  localparam int PH_W   = ctrWidth(TRCAL + 1);

  pie_state_e      state_q;
  logic            pre_q, last_q, busy_q, tx_out_q, done_q, underrun_q;
  pie_sym_e        symSel;
  logic            loadSym, lowOnly, take, level, symLast;
  logic [PH_W-1:0] symLenSel;

  function automatic logic [PH_W-1:0] symLen(input pie_sym_e s);
    case (s)
      SYM_DELIM: symLen = PH_W'(DELIM);
      SYM_DATA1: symLen = PH_W'(DATA1);
      SYM_RTCAL: symLen = PH_W'(RTCAL);
      SYM_TRCAL: symLen = PH_W'(TRCAL);
      default:   symLen = PH_W'(TARI);
    endcase
  endfunction

  // A bit may only be taken in the last cycle of a symbol that needs a successor bit.
  assign in_rdy = symLast && (((state_q == ST_RTCAL) && !pre_q) ||
                              (state_q == ST_TRCAL) ||
                              ((state_q == ST_DATA) && !last_q));
  assign take = in_rdy && in_vld;

  always_comb begin
    symSel  = SYM_DELIM;
    loadSym = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start && !done_q) begin
          loadSym = 1'b1;
          symSel  = SYM_DELIM;
        end
      end
      ST_DELIM: begin
        if (symLast) begin
          loadSym = 1'b1;
          symSel  = SYM_DATA0;
        end
      end
      ST_DATA0: begin
        if (symLast) begin
          loadSym = 1'b1;
          symSel  = SYM_RTCAL;
        end
      end
      ST_RTCAL: begin
        if (symLast && pre_q) begin
          loadSym = 1'b1;
          symSel  = SYM_TRCAL;
        end
      end
      default: ;
    endcase
    if (take) begin
      loadSym = 1'b1;
      symSel  = in_dat ? SYM_DATA1 : SYM_DATA0;
    end
    lowOnly   = (symSel == SYM_DELIM);
    symLenSel = symLen(symSel);
  end

  pie_sym_timer #(
    .TICK_N(TICK_N),
    .PW    (PW),
    .TICK_W(TICK_W),
    .PH_W  (PH_W)
  ) uTimer (
    .clk     (clk),
    .rst_n   (rst_n),
    .run     (busy_q),
    .load    (loadSym),
    .low_only(lowOnly),
    .sym_len (symLenSel),
    .level   (level),
    .sym_last(symLast)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      pre_q      <= 1'b0;
      last_q     <= 1'b0;
      busy_q     <= 1'b0;
      tx_out_q   <= 1'b1;
      done_q     <= 1'b0;
      underrun_q <= 1'b0;
    end else begin
      done_q     <= 1'b0;
      underrun_q <= 1'b0;
      tx_out_q   <= level;
      case (state_q)
        ST_IDLE: begin
          if (loadSym) begin
            state_q <= ST_DELIM;
            busy_q  <= 1'b1;
            pre_q   <= preamble_sel;
            last_q  <= 1'b0;
          end else begin
            tx_out_q <= 1'b1;
          end
        end
        ST_DELIM: if (symLast) state_q <= ST_DATA0;
        ST_DATA0: if (symLast) state_q <= ST_RTCAL;
        ST_RTCAL, ST_TRCAL, ST_DATA: begin
          if (symLast) begin
            if ((state_q == ST_RTCAL) && pre_q) begin
              state_q <= ST_TRCAL;
            end else if ((state_q == ST_DATA) && last_q) begin
              state_q  <= ST_IDLE;
              busy_q   <= 1'b0;
              tx_out_q <= 1'b1;
              done_q   <= 1'b1;
            end else if (take) begin
              state_q <= ST_DATA;
              last_q  <= in_last;
            end else begin
              state_q    <= ST_IDLE;
              busy_q     <= 1'b0;
              tx_out_q   <= 1'b1;
              underrun_q <= 1'b1;
            end
          end
        end
        default: begin
          state_q  <= ST_IDLE;
          busy_q   <= 1'b0;
          tx_out_q <= 1'b1;
        end
      endcase
    end
  end

  assign tx_out   = tx_out_q;
  assign busy     = busy_q;
  assign done     = done_q;
  assign underrun = underrun_q;

endmodule

// File: tb/tb_pie_encoder.sv
// Self-checking bench for pie_encoder: table-driven frames against a per-cycle
// waveform model, plus hand-written start-collision and mid-frame reset cases.
module tb_pie_encoder;
   import rfid_pkg::*;

   localparam int T = PIE_TICK_N;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   logic start = 1'b0;
   logic preamble_sel = 1'b0;
   logic in_dat = 1'b0;
   logic in_last = 1'b0;
   logic in_vld = 1'b0;
   logic in_rdy, tx_out, busy, done, underrun;

   // Free-running clock; inputs change and outputs are sampled on the falling edge.
   always #5 clk = ~clk;

   pie_encoder dut (
      .clk(clk),
      .rst_n(rst_n),
      .start(start),
      .preamble_sel(preamble_sel),
      .in_dat(in_dat),
      .in_last(in_last),
      .in_vld(in_vld),
      .in_rdy(in_rdy),
      .tx_out(tx_out),
      .busy(busy),
      .done(done),
      .underrun(underrun)
   );

   typedef struct {
      bit         pre;
      int         nBits;
      logic [7:0] bits;
      int         dropIdx;
      bit         holdVld;
      int         midStart;
      int         expDone;
      int         expUnderrun;
      int         expHs;
   } vec_t;

   vec_t vecs[7];
   int compared = 0;
   int mismatched = 0;
   logic expTx[0:4095];
   logic expRdy[0:4095];
   int mN;

   // Single comparison point: every check in the bench goes through here.
   task automatic checkOutput(input string name, input int actual, input int expected);
      compared++;
      if (actual != expected) begin
         mismatched++;
         $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
      end
   endtask

   task automatic addLevel(input logic lvl, input int cycles);
      for (int c = 0; c < cycles; c++) begin
         expTx[mN] = lvl;
         expRdy[mN] = 1'b0;
         mN++;
      end
   endtask

   task automatic addSym(input int len, input logic rdy);
      addLevel(1'b1, (len - PIE_PW) * T);
      addLevel(1'b0, PIE_PW * T);
      if (rdy) expRdy[mN-1] = 1'b1;
   endtask

   // Expected tx_out / in_rdy per cycle after start; endCycle is the first cycle after the frame.
   task automatic buildModel(input vec_t v, output int endCycle);
      mN = 1;
      addLevel(1'b0, PIE_DELIM * T);
      addSym(PIE_TARI, 1'b0);
      addSym(PIE_RTCAL, !v.pre);
      if (v.pre) addSym(PIE_TRCAL, 1'b1);
      for (int i = 0; i < v.nBits; i++) begin
         if (i == v.dropIdx) break;
         addSym(v.bits[i] ? PIE_DATA1 : PIE_TARI, i != v.nBits - 1);
      end
      endCycle = mN;
      for (int k = 0; k < 8; k++) begin
         expTx[mN+k] = 1'b1;
         expRdy[mN+k] = 1'b0;
      end
   endtask

   // Run one frame from a table vector, feeding bits over the handshake and scoring the waveform.
   task automatic applyStimulus(input vec_t v, input int id);
      int endC, idx, hs, doneC, doneCnt, undC, undCnt;
      int txBad, rdyBad, busyBad, firstTx, firstRdy;
      buildModel(v, endC);
      idx = 0; hs = 0; doneC = 0; doneCnt = 0; undC = 0; undCnt = 0;
      txBad = 0; rdyBad = 0; busyBad = 0; firstTx = 0; firstRdy = 0;
      @(negedge clk);
      preamble_sel = v.pre;
      start = 1'b1;
      in_vld = v.holdVld;
      for (int n = 1; n <= endC + 5; n++) begin
         @(negedge clk);
         start = (n == v.midStart);
         if (tx_out !== expTx[n]) begin
            txBad++;
            if (firstTx == 0) firstTx = n;
         end
         if (in_rdy !== expRdy[n]) begin
            rdyBad++;
            if (firstRdy == 0) firstRdy = n;
         end
         if (busy !== (n < endC)) busyBad++;
         if (done === 1'b1) begin
            doneCnt++;
            if (doneC == 0) doneC = n;
         end
         if (underrun === 1'b1) begin
            undCnt++;
            if (undC == 0) undC = n;
         end
         in_vld = v.holdVld || (idx < v.nBits && idx != v.dropIdx);
         in_dat = (idx < v.nBits && idx < 8) ? v.bits[idx] : 1'b0;
         in_last = (idx == v.nBits - 1);
         if (in_rdy === 1'b1 && in_vld) begin
            hs++;
            idx++;
         end
      end
      in_vld = 1'b0;
      in_dat = 1'b0;
      in_last = 1'b0;
      preamble_sel = 1'b0;
      checkOutput($sformatf("v%0d txWave(first bad cycle %0d)", id, firstTx), txBad, 0);
      checkOutput($sformatf("v%0d rdyWave(first bad cycle %0d)", id, firstRdy), rdyBad, 0);
      checkOutput($sformatf("v%0d busyWave", id), busyBad, 0);
      checkOutput($sformatf("v%0d doneCycle", id), doneC, v.expDone);
      checkOutput($sformatf("v%0d donePulses", id), doneCnt, (v.expDone != 0) ? 1 : 0);
      checkOutput($sformatf("v%0d underrunCycle", id), undC, v.expUnderrun);
      checkOutput($sformatf("v%0d underrunPulses", id), undCnt, (v.expUnderrun != 0) ? 1 : 0);
      checkOutput($sformatf("v%0d handshakes", id), hs, v.expHs);
   endtask

   // Hard stop if something upstream hangs despite the bounded loops.
   initial begin
      #5_000_000;
      $display("[TB] FAIL watchdog: simulation time limit reached");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      int dC, dC2;
      vecs[0] = '{pre:1'b1, nBits:2, bits:8'b0000_0001, dropIdx:-1, holdVld:1'b0, midStart:500, expDone:2121, expUnderrun:0, expHs:2};
      vecs[1] = '{pre:1'b0, nBits:1, bits:8'b0000_0000, dropIdx:-1, holdVld:1'b0, midStart:0, expDone:961, expUnderrun:0, expHs:1};
      vecs[2] = '{pre:1'b1, nBits:4, bits:8'b0000_1101, dropIdx:2, holdVld:1'b0, midStart:0, expDone:0, expUnderrun:2121, expHs:2};
      vecs[3] = '{pre:1'b0, nBits:2, bits:8'b0000_0000, dropIdx:0, holdVld:1'b0, midStart:0, expDone:0, expUnderrun:801, expHs:0};
      vecs[4] = '{pre:1'b0, nBits:8, bits:8'b1011_0010, dropIdx:-1, holdVld:1'b1, midStart:0, expDone:2561, expUnderrun:0, expHs:8};
      vecs[5] = '{pre:1'b1, nBits:1, bits:8'b0000_0000, dropIdx:-1, holdVld:1'b0, midStart:0, expDone:1841, expUnderrun:0, expHs:1};
      vecs[6] = '{pre:1'b0, nBits:2, bits:8'b0000_0011, dropIdx:-1, holdVld:1'b0, midStart:1200, expDone:1361, expUnderrun:0, expHs:2};

      repeat (3) @(negedge clk);
      checkOutput("rst tx_out", tx_out, 1);
      checkOutput("rst busy", busy, 0);
      checkOutput("rst in_rdy", in_rdy, 0);
      checkOutput("rst done", done, 0);
      checkOutput("rst underrun", underrun, 0);
      rst_n = 1'b1;
      repeat (2) @(negedge clk);
      checkOutput("idle tx_out", tx_out, 1);
      checkOutput("idle busy", busy, 0);

      for (int i = 0; i < 7; i++) applyStimulus(vecs[i], i);

      // start in the done cycle is ignored; start one cycle later opens a new frame.
      @(negedge clk);
      preamble_sel = 1'b0;
      start = 1'b1;
      in_vld = 1'b1;
      in_dat = 1'b0;
      in_last = 1'b1;
      dC = 0;
      for (int n = 1; n <= 1200; n++) begin
         @(negedge clk);
         start = (n == 300);
         if (done === 1'b1) begin
            dC = n;
            break;
         end
      end
      checkOutput("t4 doneCycle", dC, 961);
      start = 1'b1;
      @(negedge clk);
      checkOutput("t4 startInDone tx_out", tx_out, 1);
      checkOutput("t4 startInDone busy", busy, 0);
      @(negedge clk);
      start = 1'b0;
      checkOutput("t4 restart tx_out", tx_out, 0);
      checkOutput("t4 restart busy", busy, 1);
      dC2 = 0;
      for (int n = 2; n <= 1200; n++) begin
         @(negedge clk);
         if (done === 1'b1) begin
            dC2 = n;
            break;
         end
      end
      checkOutput("t4 restart doneCycle", dC2, 961);
      in_vld = 1'b0;
      in_last = 1'b0;

      // Asynchronous reset in the low tail of TRcal (cycles 1601..1680).
      @(negedge clk);
      preamble_sel = 1'b1;
      start = 1'b1;
      for (int n = 1; n <= 1620; n++) begin
         @(negedge clk);
         start = 1'b0;
      end
      preamble_sel = 1'b0;
      checkOutput("t5 trcal low before reset", tx_out, 0);
      #2;
      rst_n = 1'b0;
      #1;
      checkOutput("t5 async tx_out", tx_out, 1);
      checkOutput("t5 async busy", busy, 0);
      checkOutput("t5 async in_rdy", in_rdy, 0);
      @(negedge clk);
      rst_n = 1'b1;
      repeat (3) @(negedge clk);
      checkOutput("t5 post-reset done", done, 0);
      checkOutput("t5 post-reset underrun", underrun, 0);
      checkOutput("t5 post-reset tx_out", tx_out, 1);
      applyStimulus(vecs[0], 7);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
